// File: rtl/mux_scan_nx1_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_pkg
//  Description : Shared constants and helpers for the scanning N:1 channel
//                multiplexer (mode encodings, dwell counter width, ring
//                index arithmetic).
//  Revision    : 1.0 - initial release
// ============================================================================
package mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    localparam int DWELL_W = 8;

    // Index step around a ring of n channels; c < n and 1 <= i <= n, so a
    // single conditional subtract replaces a general modulo.
    function automatic int ring_add(input int c, input int i, input int n);
        int s;
        s = c + i;
        return (s >= n) ? (s - n) : s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux_scan_nx1_rr_next_sel.sv
`default_nettype none
// ============================================================================
//  Module      : rr_next_sel
//  Description : Combinational round-robin successor search. Looks for the
//                first enabled channel strictly after `cur`, wrapping
//                N-1 -> 0 and ending at `cur` itself (rotated priority
//                encoder). Flags whether anything was found and whether the
//                result wrapped (result index <= cur).
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_next_sel
    import mux_pkg::*;
#(
    parameter int N     = 8,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [SEL_W-1:0] cur,
    input  logic [N-1:0]     mask,
    output logic [SEL_W-1:0] next,
    output logic             found,
    output logic             wrapped
);

    // Walk the mask starting one past cur; the first hit in rotated order wins.
    always_comb begin
        next    = cur;
        found   = 1'b0;
        wrapped = 1'b0;
        for (int i = 1; i <= N; i++) begin
            if (!found && mask[ring_add(int'(cur), i, N)]) begin
                next  = SEL_W'(ring_add(int'(cur), i, N));
                found = 1'b1;
            end
        end
        // A lone enabled channel finds itself, which also counts as a wrap.
        wrapped = found && (next <= cur);
    end

endmodule
`default_nettype wire

// File: rtl/mux_scan_nx1.sv
`default_nettype none
// ============================================================================
//  Module      : mux_scan_nx1
//  Description : Registered N-to-1 multiplexer of W-bit channels. Manual mode
//                follows an external select; scan mode round-robins over an
//                enable mask, holding each channel for dwell+1 cycles, and
//                pulses `wrap` whenever the scan returns to a lower or equal
//                index. All outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_scan_nx1
    import mux_pkg::*;
#(
    parameter int N     = 8,
    parameter int W     = 8,
    parameter int SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
    input  logic [N-1:0]       en_mask,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [N*W-1:0]     din,
    output logic [W-1:0]       dout,
    output logic               dout_valid,
    output logic [SEL_W-1:0]   cur_sel,
    output logic               wrap
);

    logic [SEL_W-1:0]   r_cur_sel;
    logic [DWELL_W-1:0] r_cnt;
    logic [W-1:0]       r_dout;
    logic               r_dout_valid;
    logic               r_wrap;

    logic [SEL_W-1:0]   w_next;
    logic               w_found;
    logic               w_wrapped;
    logic               w_sel_ok;
    logic               w_advance;

    rr_next_sel #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_rr_next_sel (
        .cur     (r_cur_sel),
        .mask    (en_mask),
        .next    (w_next),
        .found   (w_found),
        .wrapped (w_wrapped)
    );

    // Out-of-range selects (non power-of-two N) are ignored; an advance needs
    // the dwell elapsed (>= so a lowered dwell does not wait for a 255 wrap)
    // and at least one enabled channel.
    always_comb begin
        w_sel_ok  = (int'(sel) < N);
        w_advance = (r_cnt >= dwell) && w_found;
    end

    // Selection, dwell counting and the registered data path.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur_sel    <= '0;
            r_cnt        <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_wrap       <= 1'b0;
        end else begin
            r_dout <= din[r_cur_sel*W +: W];
            if (mode == MODE_MANUAL) begin
                r_dout_valid <= 1'b1;
                r_wrap       <= 1'b0;
                r_cnt        <= '0;
                if (w_sel_ok) begin
                    r_cur_sel <= sel;
                end
            end else begin
                r_dout_valid <= en_mask[r_cur_sel];
                if (w_advance) begin
                    r_cnt     <= '0;
                    r_cur_sel <= w_next;
                    r_wrap    <= w_wrapped;
                end else begin
                    r_cnt  <= r_cnt + DWELL_W'(1);
                    r_wrap <= 1'b0;
                end
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign cur_sel    = r_cur_sel;
    assign wrap       = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_nx1.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_scan_nx1
//  Description : Self-checking bench for mux_scan_nx1 (N=8 main instance,
//                N=6 instance for out-of-range select handling).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_scan_nx1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mode = 1'b0;
    logic [2:0]  sel = '0;
    logic [7:0]  en_mask = '0;
    logic [7:0]  dwell = '0;
    logic [63:0] din = '0;
    logic [7:0]  dout;
    logic        dout_valid;
    logic [2:0]  cur_sel;
    logic        wrap;

    logic        mode6 = 1'b0;
    logic [2:0]  sel6 = '0;
    logic [5:0]  en_mask6 = '0;
    logic [47:0] din6 = '0;
    logic [7:0]  dout6;
    logic        dout_valid6;
    logic [2:0]  cur_sel6;
    logic        wrap6;

    int checks = 0;
    int errors = 0;

    // reference model state
    int       m_sel, m_cnt, m_wrap, m_valid;
    int       m_dout;
    int       wrap_count;

    always #5 clk = ~clk;

    mux_scan_nx1 #(.N(8), .W(8)) dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel), .en_mask(en_mask),
        .dwell(dwell), .din(din), .dout(dout), .dout_valid(dout_valid),
        .cur_sel(cur_sel), .wrap(wrap)
    );

    mux_scan_nx1 #(.N(6), .W(8)) dut6 (
        .clk(clk), .rst(rst), .mode(mode6), .sel(sel6), .en_mask(en_mask6),
        .dwell(8'd0), .din(din6), .dout(dout6), .dout_valid(dout_valid6),
        .cur_sel(cur_sel6), .wrap(wrap6)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock from the current inputs, clock the DUT,
    // then compare all outputs.
    task automatic step(input string tag);
        int nxt;
        if (rst) begin
            m_sel = 0; m_cnt = 0; m_dout = 0; m_valid = 0; m_wrap = 0;
        end else begin
            m_dout = int'(din[m_sel*8 +: 8]);
            if (mode == 1'b0) begin
                m_valid = 1; m_wrap = 0; m_cnt = 0;
                if (int'(sel) < 8) m_sel = int'(sel);
            end else begin
                m_valid = int'(en_mask[m_sel]);
                m_wrap  = 0;
                if (m_cnt >= int'(dwell) && en_mask != 8'h00) begin
                    nxt = -1;
                    for (int k = 1; k <= 8; k++)
                        if (nxt < 0 && en_mask[(m_sel + k) % 8]) nxt = (m_sel + k) % 8;
                    m_wrap = (nxt <= m_sel) ? 1 : 0;
                    m_sel  = nxt;
                    m_cnt  = 0;
                end else begin
                    m_cnt = (m_cnt + 1) % 256;
                end
            end
        end
        @(posedge clk); #1;
        chk({tag, ".dout"},    32'(dout),       32'(m_dout));
        chk({tag, ".valid"},   32'(dout_valid), 32'(m_valid));
        chk({tag, ".cur_sel"}, 32'(cur_sel),    32'(m_sel));
        chk({tag, ".wrap"},    32'(wrap),       32'(m_wrap));
        if (wrap === 1'b1) wrap_count++;
    endtask

    task automatic set_fixed_din();
        for (int k = 0; k < 8; k++) din[k*8 +: 8] = 8'h10 + 8'(k);
    endtask

    initial begin
        set_fixed_din();
        for (int k = 0; k < 6; k++) din6[k*8 +: 8] = 8'h10 + 8'(k);

        // reset held two cycles with arbitrary mode
        rst = 1'b1; mode = 1'b1; en_mask = 8'hFF;
        step("rst0");
        step("rst1");
        chk("rst.dout", 32'(dout), 32'h0);
        chk("rst.valid", 32'(dout_valid), 32'h0);
        chk("rst.cur_sel", 32'(cur_sel), 32'h0);
        chk("rst.wrap", 32'(wrap), 32'h0);

        // manual sweep: cur_sel follows sel, dout lags by one more cycle
        rst = 1'b0; mode = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sel = 3'(i);
            step("man");
            chk("man.cur_sel", 32'(cur_sel), 32'(i));
            chk("man.wrap", 32'(wrap), 32'h0);
        end
        step("man_tail");
        chk("man.dout7", 32'(dout), 32'h17);

        // full scan, dwell 0: resumes from 7, so first advance lands on 0
        mode = 1'b1; en_mask = 8'hFF; dwell = 8'd0;
        wrap_count = 0;
        for (int i = 0; i < 10; i++) begin
            step("full");
            chk("full.cur_sel", 32'(cur_sel), 32'(i % 8));
            chk("full.wrap", 32'(wrap), (i % 8 == 0) ? 32'h1 : 32'h0);
        end

        // sparse scan: 2,5,7 each held three cycles, one wrap per lap
        en_mask = 8'b1010_0100; dwell = 8'd2;
        wrap_count = 0;
        for (int i = 0; i < 24; i++) step("sparse");
        chk("sparse.wraps", 32'(wrap_count >= 2), 32'h1);

        // empty mask: frozen selection, valid drops
        en_mask = 8'h00;
        for (int i = 0; i < 5; i++) begin
            step("empty");
            chk("empty.valid", 32'(dout_valid), 32'h0);
            chk("empty.wrap", 32'(wrap), 32'h0);
        end

        // single channel 3, dwell 1: wrap every two cycles, stays on 3
        en_mask = 8'h08; dwell = 8'd1;
        for (int i = 0; i < 4; i++) step("single_in");
        chk("single.cur_sel", 32'(cur_sel), 32'h3);
        wrap_count = 0;
        for (int i = 0; i < 8; i++) step("single");
        chk("single.wraps", 32'(wrap_count), 32'h4);

        // mid-scan reset once cur_sel reaches 5 (bounded wait)
        en_mask = 8'hFF; dwell = 8'd0;
        begin
            int guard = 0;
            while (cur_sel !== 3'd5 && guard < 40) begin
                step("seek5");
                guard++;
            end
        end
        chk("seek5.reached", 32'(cur_sel), 32'h5);
        rst = 1'b1;
        step("midrst");
        chk("midrst.cur_sel", 32'(cur_sel), 32'h0);
        chk("midrst.dout", 32'(dout), 32'h0);
        rst = 1'b0;
        step("resume0");
        step("resume1");
        mode = 1'b0; sel = 3'd6;
        step("to_man");
        chk("to_man.cur_sel", 32'(cur_sel), 32'h6);
        step("to_man2");
        chk("to_man.dout", 32'(dout), 32'h16);

        // randomized operation against the model
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            sel = 3'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 3))
                    0: en_mask = 8'h00;
                    1: en_mask = 8'h01 << $urandom_range(0, 7);
                    default: en_mask = 8'($urandom);
                endcase
            end
            if ($urandom_range(0, 14) == 0)
                dwell = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
            din = {$urandom, $urandom};
            step("rand");
        end
        rst = 1'b0;

        // N=6 instance: select 7 is out of range and must be ignored
        mode6 = 1'b0; sel6 = 3'd4;
        @(posedge clk); #1;
        chk("n6.sel4", 32'(cur_sel6), 32'h4);
        sel6 = 3'd7;
        @(posedge clk); #1;
        chk("n6.sel7_ignored", 32'(cur_sel6), 32'h4);
        @(posedge clk); #1;
        chk("n6.dout", 32'(dout6), 32'h14);
        sel6 = 3'd5;
        @(posedge clk); #1;
        chk("n6.sel5", 32'(cur_sel6), 32'h5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux_scan_nx1.md
Name: mux_scan_nx1

Overview:
- Parametrised, registered N-to-1 channel multiplexer with W-bit channels.
- Generalises the team's fixed 8:1 one-bit gate-level mux.
- Two modes: manual (external select) and auto-scan. Auto-scan round-robins over a channel enable mask, holding each channel for a programmable dwell time.
- Sits between a bank of sensor/data sources and a single downstream consumer. Reports which channel is live and flags each scan wrap.

Parameters:
- N, 8, number of input channels (2..256).
- W, 8, data width per channel in bits.
- SEL_W, $clog2(N), select width (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- mode  in  1  0 = manual, 1 = scan.
- sel  in  SEL_W  manual channel select.
- en_mask  in  N  scan enable, bit k enables channel k.
- dwell  in  8  scan dwell: channel held dwell+1 cycles.
- din  in  N*W  packed channel data; channel k = din[k*W +: W].
- dout  out  W  registered selected data.
- dout_valid  out  1  registered qualifier for dout.
- cur_sel  out  SEL_W  currently selected channel (register).
- wrap  out  1  one-cycle pulse when scan wraps.

Behaviour:
- Reset (rst=1 at a clock edge) takes priority over everything and may be applied mid-operation. Next cycle: dout=0, dout_valid=0, cur_sel=0, wrap=0, internal dwell counter cnt=0.
- Data path latency is 1 cycle.
  - dout(t+1) = channel cur_sel(t) of din(t).
  - Manual: dout_valid(t+1) = 1.
  - Scan: dout_valid(t+1) = en_mask[cur_sel(t)].
- Manual mode:
  - cur_sel <= sel when sel < N.
  - sel >= N (only possible when N is not a power of 2) is ignored; cur_sel holds.
  - cnt held at 0; wrap=0.
- Scan mode:
  - cnt increments each cycle.
  - When cnt == dwell: cnt <= 0 and cur_sel <= next enabled index. Search is strictly above cur_sel, wrapping N-1 -> 0, ending at cur_sel itself.
  - dwell=0 advances every cycle.
- wrap is a registered pulse, high for exactly one cycle, in the same cycle cur_sel takes the new value, whenever the advance result is <= old cur_sel. A single enabled channel therefore pulses wrap on every advance, with cur_sel unchanged.
- en_mask all zero in scan: cur_sel holds, cnt keeps counting, no advance, wrap=0, dout_valid=0 next cycle.
- If cur_sel is disabled at a scan entry or after a mask change, it stays until the next advance point, with valid=0 meanwhile.
- Mode switch scan->manual: next cycle cur_sel = sel, cnt = 0.
- Mode switch manual->scan: scan resumes from current cur_sel with cnt = 0. The first advance occurs dwell+1 cycles later.
- Changes to en_mask or dwell take effect at the next compare. Lowering dwell below cnt causes an advance only after cnt wraps at 255->0 then reaches dwell. Implementers must use `>=` compare to avoid this: advance when cnt >= dwell.
- No combinational path from inputs to outputs.

Decomposition:
- Package mux_pkg:
  - MODE_MANUAL=1'b0 and MODE_SCAN=1'b1 constants.
  - DWELL_W=8 constant.
- One sub-module, rr_next_sel:
  - Combinational, parametrised by N.
  - Inputs: cur index and mask.
  - Outputs: next enabled index, found flag, wrapped flag.
  - Implemented as a rotated priority encoder.
- The top level holds the cur_sel, cnt, dout, dout_valid and wrap registers plus the mode logic.

Test Plan:
- All tests use N=8, W=8, with channel k data = 8'h10+k.
- Reset: hold rst=1 for 2 cycles with arbitrary din/mode -> dout=8'h00, dout_valid=0, cur_sel=0, wrap=0. Release -> first manual sample appears 1 cycle later.
- Manual sweep: mode=0, sel=0..7, one cycle each -> cur_sel follows 1 cycle later. dout = 8'h10..8'h17 lagging cur_sel by 1 cycle, dout_valid=1, wrap never asserted.
- Full scan: mode=1, en_mask=8'hFF, dwell=0 -> cur_sel 0,1,..,7,0,1. wrap high only in the cycle cur_sel becomes 0. dout tracks cur_sel with 1-cycle lag.
- Sparse scan: en_mask=8'b1010_0100, dwell=2 -> cur_sel visits 2,5,7,2, each held 3 cycles. wrap pulses once on 7->2. dout = 8'h12, 8'h15, 8'h17 blocks, valid=1.
- Empty mask and single channel:
  - en_mask=0 -> cur_sel frozen, dout_valid=0 next cycle, wrap=0.
  - Then en_mask=8'h08, dwell=1 -> cur_sel=3 at next advance; after that wrap pulses every 2 cycles, cur_sel stays 3.
- Mid-scan reset and mode switch:
  - Scanning with cur_sel=5, assert rst one cycle -> all outputs zero next cycle.
  - Resume in scan from 0, then mode=0 with sel=6 -> cur_sel=6 next cycle, dout=8'h16 the cycle after.
  - Separate build with N=6: sel=7 in manual -> cur_sel unchanged.
